// File: rtl/mem_port_scheduler.sv
// Shares one main-memory request port between the I-cache and D-cache: round-robin grant,
// source-tagged requests, per-source read throttling and response-beat steering by tag.
module mem_port_scheduler #(
    parameter int ADDR_W  = 28,
    parameter int TAG_W   = 5,
    parameter int BEATS   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_resp_valid,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [TAG_W-1:0]  mem_req_tag,
    input  logic              mem_req_data_valid,
    input  logic              mem_req_data_ready,
    input  logic              mem_resp_valid,
    input  logic [TAG_W-1:0]  mem_resp_tag,
    output logic              resp_err,
    output logic [1:0]        o_dbg_state
);

    localparam int SEQ_W  = TAG_W - 1;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_OUT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_src;
    logic               r_rr;
    logic [SEQ_W-1:0]   r_ic_seq;
    logic [SEQ_W-1:0]   r_dc_seq;
    logic [CNT_W-1:0]   r_ic_out;
    logic [CNT_W-1:0]   r_dc_out;
    logic [BEAT_W-1:0]  r_wbeat;
    logic [BEAT_W-1:0]  r_rbeat;
    logic               r_err;

    logic               w_src;
    logic               w_pick;
    logic               w_ic_elig;
    logic               w_dc_elig;
    logic               w_mem_valid;
    logic               w_rw;
    logic               w_issue;
    logic               w_wbeat_hs;
    logic               w_resp_last;
    logic               w_ic_inc;
    logic               w_dc_inc;
    logic               w_ic_dec;
    logic               w_dc_dec;
    logic [SEQ_W-1:0]   w_seq_sel;

    // Writes bypass the outstanding-read limit; when both are eligible the one not served last wins.
    assign w_ic_elig  = ic_req_valid && (r_ic_out < MAX_C);
    assign w_dc_elig  = dc_req_valid && (dc_req_rw || (r_dc_out < MAX_C));
    assign w_pick     = (w_ic_elig && w_dc_elig) ? ~r_rr : w_dc_elig;
    assign w_wbeat_hs = mem_req_data_valid && mem_req_data_ready;

    // Request handshake: a transfer happens on a rising edge where mem_req_valid && mem_req_ready;
    // once mem_req_valid rises it stays high with stable addr/rw/tag until that edge, and the
    // granted cache sees its *_req_ready high only in that transfer cycle.
    always_comb begin
        w_next      = r_state;
        w_src       = r_src;
        w_mem_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reset && (w_ic_elig || w_dc_elig)) begin
                    w_src       = w_pick;
                    w_mem_valid = 1'b1;
                    w_next      = S_REQ;
                end
            end
            S_REQ: w_mem_valid = 1'b1;
            S_WDATA: begin
                if (w_wbeat_hs && (r_wbeat == LAST_BEAT)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        w_rw    = w_src & dc_req_rw;
        w_issue = w_mem_valid && mem_req_ready;
        if (w_issue) w_next = w_rw ? S_WDATA : S_IDLE;
    end

    assign w_seq_sel     = w_src ? r_dc_seq : r_ic_seq;
    assign mem_req_valid = w_mem_valid;
    assign mem_req_rw    = w_mem_valid & w_rw;
    assign mem_req_addr  = w_mem_valid ? (w_src ? dc_req_addr : ic_req_addr) : '0;
    assign mem_req_tag   = w_mem_valid ? {w_seq_sel, w_src} : '0;
    assign ic_req_ready  = w_issue && !w_src;
    assign dc_req_ready  = w_issue && w_src;
    assign ic_resp_valid = mem_resp_valid && !mem_resp_tag[0];
    assign dc_resp_valid = mem_resp_valid && mem_resp_tag[0];
    assign resp_err      = r_err;
    assign o_dbg_state   = r_state;

    assign w_resp_last = mem_resp_valid && (r_rbeat == LAST_BEAT);
    assign w_ic_inc    = w_issue && !w_src && !w_rw;
    assign w_dc_inc    = w_issue && w_src && !w_rw;
    assign w_ic_dec    = w_resp_last && !mem_resp_tag[0];
    assign w_dc_dec    = w_resp_last && mem_resp_tag[0];

    // Same-cycle issue and retire cancel; a retire against zero holds zero (flagged via r_err).
    function automatic logic [CNT_W-1:0] next_out(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] n;
        n = cur;
        if (inc && (!dec || (cur == '0))) n = cur + 1'b1;
        else if (!inc && dec && (cur != '0)) n = cur - 1'b1;
        return n;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_src    <= 1'b0;
            r_rr     <= 1'b0;
            r_ic_seq <= '0;
            r_dc_seq <= '0;
            r_ic_out <= '0;
            r_dc_out <= '0;
            r_wbeat  <= '0;
            r_rbeat  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_src   <= w_src;
            if (w_issue) begin
                r_rr <= w_src;
                if (w_src) r_dc_seq <= r_dc_seq + 1'b1;
                else       r_ic_seq <= r_ic_seq + 1'b1;
            end
            if ((r_state == S_WDATA) && w_wbeat_hs)
                r_wbeat <= (r_wbeat == LAST_BEAT) ? '0 : r_wbeat + 1'b1;
            if (mem_resp_valid)
                r_rbeat <= (r_rbeat == LAST_BEAT) ? '0 : r_rbeat + 1'b1;
            r_ic_out <= next_out(r_ic_out, w_ic_inc, w_ic_dec);
            r_dc_out <= next_out(r_dc_out, w_dc_inc, w_dc_dec);
            if ((w_ic_dec && (r_ic_out == '0)) || (w_dc_dec && (r_dc_out == '0)))
                r_err <= 1'b1;
        end
    end

endmodule
